// File: rtl/bcd_counter_bank.sv
// Bank of DIGITS independent digit counters joined by a registered carry/borrow
// chain. Each digit has its own limit, the bank supports parallel load, and a
// wrap of the top digit is reported on a one-cycle overflow pulse.
module bcd_counter_bank #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned RADIX    = 10,
    parameter int unsigned WRAP_TOP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     inc,
    input  logic                  up_down_sel,
    input  logic                  carry_en,
    input  logic                  max_en,
    input  logic [4*DIGITS-1:0]   max_val,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt_out,
    output logic                  overflow,
    output logic                  busy
);

    // Largest value a digit may hold at its natural modulus.
    localparam logic [3:0] DigitMax = 4'(RADIX - 1);

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] step_val;
    logic [DIGITS-1:0]      carry;
    logic [DIGITS-1:0]      pend_q, pend_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;

    // One up/down step of a digit against limit lim. Result is {wrapped, value}.
    function automatic logic [4:0] step_digit(input logic [3:0] v,
                                              input logic [3:0] lim,
                                              input logic       up);
        logic [4:0] r;
        if (up) begin
            if (v >= lim) r = {1'b1, 4'd0};
            else          r = {1'b0, v + 4'd1};
        end else begin
            // A value above the limit (limit lowered since the last step)
            // is treated like zero: it borrows and reloads the limit.
            if (v == 4'd0 || v > lim) r = {1'b1, lim};
            else                      r = {1'b0, v - 4'd1};
        end
        return r;
    endfunction

    // Saturate a nibble to the natural digit range.
    function automatic logic [3:0] clamp_digit(input logic [3:0] v);
        return (v > DigitMax) ? DigitMax : v;
    endfunction

    for (genvar j = 0; j < DIGITS; j++) begin : g_digit
        logic [3:0] lim;
        logic [1:0] n_steps;
        logic [4:0] s1, s2;
        logic [3:0] val;
        logic       cy;

        // Per-digit limit and up to two successive steps (local strobe plus
        // incoming carry). Two wraps in one cycle need lim == 0, so a single
        // carry out is always enough.
        always_comb begin
            lim     = clamp_digit(max_en ? max_val[4*j +: 4] : DigitMax);
            n_steps = {1'b0, inc[j]} + {1'b0, pend_q[j]};
            s1      = step_digit(cnt_q[j], lim, up_down_sel);
            s2      = step_digit(s1[3:0], lim, up_down_sel);
            val     = cnt_q[j];
            cy      = 1'b0;
            case (n_steps)
                2'd1: begin
                    val = s1[3:0];
                    cy  = s1[4];
                end
                2'd2: begin
                    val = s2[3:0];
                    cy  = s1[4] | s2[4];
                end
                default: begin
                    val = cnt_q[j];
                    cy  = 1'b0;
                end
            endcase
        end

        assign step_val[j] = val;
        assign carry[j]    = cy;
    end

    // Bank next state: load wins over stepping; carries advance one digit.
    always_comb begin
        cnt_d      = cnt_q;
        pend_d     = '0;
        overflow_d = 1'b0;
        if (load) begin
            for (int unsigned j = 0; j < DIGITS; j++) begin
                cnt_d[j] = clamp_digit(load_val[4*j +: 4]);
            end
        end else begin
            cnt_d      = step_val;
            overflow_d = carry[DIGITS-1];
            for (int unsigned j = 1; j < DIGITS; j++) begin
                pend_d[j] = carry[j-1] & carry_en;
            end
            pend_d[0] = carry[DIGITS-1] & carry_en & (WRAP_TOP != 0);
        end
        busy_d = |pend_d;
    end

    // State registers with synchronous reset taking priority over load/inc.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign cnt_out  = cnt_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Directed bench for bcd_counter_bank: the driver pushes hand-computed expected
// post-edge state into a queue, a monitor pops and compares after every edge.
module tb_bcd_counter_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  inc = '0;
    logic        up_down_sel = 1'b1;
    logic        carry_en = 1'b1;
    logic        max_en = 1'b0;
    logic [15:0] max_val = '0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] cnt_out;
    logic        overflow;
    logic        busy;

    typedef struct {
        logic [15:0] cnt;
        logic        ovf;
        logic        bsy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_counter_bank #(
        .DIGITS   (4),
        .RADIX    (10),
        .WRAP_TOP (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inc         (inc),
        .up_down_sel (up_down_sel),
        .carry_en    (carry_en),
        .max_en      (max_en),
        .max_val     (max_val),
        .load        (load),
        .load_val    (load_val),
        .cnt_out     (cnt_out),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per edge, compared 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({cnt_out, overflow, busy} !== {e.cnt, e.ovf, e.bsy}) begin
                    errors++;
                    $display("FAIL %s: got cnt=%h ovf=%b busy=%b, want cnt=%h ovf=%b busy=%b",
                             e.name, cnt_out, overflow, busy, e.cnt, e.ovf, e.bsy);
                end
            end
        end
    end

    // Drive one cycle of inputs (called at a negedge) and queue the state
    // expected after the following posedge.
    task automatic cyc(input logic [3:0] i, input logic ld, input logic [15:0] lv,
                       input logic rst, input logic [15:0] ec, input logic eo,
                       input logic eb, input string nm);
        exp_t e;
        inc      = i;
        load     = ld;
        load_val = lv;
        reset    = rst;
        e.cnt  = ec;
        e.ovf  = eo;
        e.bsy  = eb;
        e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset, then ten pulses on digit 0 counting up.
        cyc(4'h0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 1'b0, "reset");
        for (int k = 1; k <= 9; k++) begin
            cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'(k), 1'b0, 1'b0, "t1_count");
        end
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b1, "t1_wrap");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0010, 1'b0, 1'b0, "t1_carry");

        // Carry ripples one digit per clock.
        cyc(4'h0, 1'b1, 16'h0999, 1'b0, 16'h0999, 1'b0, 1'b0, "t2_load");
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0990, 1'b0, 1'b1, "t2_rip0");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0900, 1'b0, 1'b1, "t2_rip1");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b1, "t2_rip2");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h1000, 1'b0, 1'b0, "t2_rip3");

        // Top wrap feeds digit 0 (ring) and pulses overflow.
        cyc(4'h0, 1'b1, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0, "t3_load");
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h9990, 1'b0, 1'b1, "t3_rip0");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h9900, 1'b0, 1'b1, "t3_rip1");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h9000, 1'b0, 1'b1, "t3_rip2");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1, 1'b1, "t3_ovf");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0001, 1'b0, 1'b0, "t3_ring");

        // Down count with limits; F nibbles clamp to 9.
        cyc(4'h0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 1'b0, "t4_reset");
        up_down_sel = 1'b0;
        max_en      = 1'b1;
        max_val     = 16'hF9F5;
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0005, 1'b0, 1'b1, "t4_borrow0");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0095, 1'b0, 1'b1, "t4_borrow1");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0995, 1'b0, 1'b1, "t4_borrow2");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h9995, 1'b1, 1'b1, "t4_borrow3");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h9994, 1'b0, 1'b0, "t4_ring");
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h9993, 1'b0, 1'b0, "t4_dec3");
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h9992, 1'b0, 1'b0, "t4_dec2");
        // Lowered limit below current value: down step reloads limit, borrows.
        max_val = 16'hF9F1;
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h9991, 1'b0, 1'b1, "t4_above_lim");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h9981, 1'b0, 1'b0, "t4_above_lim_c");
        up_down_sel = 1'b1;
        max_en      = 1'b0;
        max_val     = 16'h0000;

        // Local strobe coincides with incoming carry: two steps in one cycle.
        cyc(4'h0, 1'b1, 16'h0089, 1'b0, 16'h0089, 1'b0, 1'b0, "t5_load");
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0080, 1'b0, 1'b1, "t5_wrap0");
        cyc(4'h2, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b1, "t5_double");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0100, 1'b0, 1'b0, "t5_fwd");

        // Reset beats load; load clears pending carry, clamps, ignores inc.
        cyc(4'h0, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, "t6_rst_load");
        cyc(4'h0, 1'b1, 16'h0009, 1'b0, 16'h0009, 1'b0, 1'b0, "t6_load");
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b1, "t6_pend");
        cyc(4'hF, 1'b1, 16'h0F0F, 1'b0, 16'h0909, 1'b0, 1'b0, "t6_load_clamp");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0909, 1'b0, 1'b0, "t6_no_carry");

        // Independent digits; zero limits; overflow regardless of carry_en.
        cyc(4'h0, 1'b1, 16'h0009, 1'b0, 16'h0009, 1'b0, 1'b0, "t7_load");
        carry_en = 1'b0;
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, "t7_nocarry");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, "t7_hold");
        max_en  = 1'b1;
        max_val = 16'h0000;
        cyc(4'h1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, "t7_lim0");
        cyc(4'h8, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1, 1'b0, "t7_top_ovf");
        cyc(4'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, "t7_ovf_clr");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
